// File: rtl/eq_pkg.sv
// Shared constants and types for the keyboard-driven 12-band EQ dial controller.
// Scan codes are PS/2 set-2 make/prefix bytes.
package eq_pkg;

  localparam int NBANDS = 12;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_RECENTRE = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_UP,
    ACT_DOWN,
    ACT_RECENTRE
  } key_action_t;

endpackage

// File: rtl/ps2_arrow_parser.sv
// Scan-byte parser: action is combinational from state and byte (zero added latency);
// no backpressure, one byte per cycle, advances only when scan_valid_i is high.
module ps2_arrow_parser
  import eq_pkg::*;
(
  input  logic        clk50,
  input  logic        reset,
  input  logic [7:0]  scan_code_i,
  input  logic        scan_valid_i,
  output key_action_t action_o
);

  parse_state_t state_q;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else if (scan_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code_i == SC_EXT)      state_q <= ST_EXT;
          else if (scan_code_i == SC_BRK) state_q <= ST_BRK;
          else                            state_q <= ST_IDLE;
        end
        ST_EXT: begin
          if (scan_code_i == SC_BRK)      state_q <= ST_EXT_BRK;
          else if (scan_code_i == SC_EXT) state_q <= ST_EXT;
          else                            state_q <= ST_IDLE;
        end
        // Byte after a break prefix is the released key; it is swallowed.
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    action_o = ACT_NONE;
    if (scan_valid_i) begin
      case (state_q)
        ST_IDLE: if (scan_code_i == SC_RECENTRE) action_o = ACT_RECENTRE;
        ST_EXT: begin
          case (scan_code_i)
            SC_LEFT:  action_o = ACT_LEFT;
            SC_RIGHT: action_o = ACT_RIGHT;
            SC_UP:    action_o = ACT_UP;
            SC_DOWN:  action_o = ACT_DOWN;
            default:  action_o = ACT_NONE;
          endcase
        end
        default: action_o = ACT_NONE;
      endcase
    end
  end

endmodule

// File: rtl/eq_dial_controller.sv
// Arrow keys pick a band and nudge its saturating dial; 1-cycle latency from byte to outputs,
// no backpressure (one byte per cycle). update pulses one cycle per real dial change or recentre.
module eq_dial_controller
  import eq_pkg::*;
#(
  parameter int DIAL_MAX    = 24,
  parameter int DIAL_CENTER = 12
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [4:0] dial31,
  output logic [4:0] dial72,
  output logic [4:0] dial150,
  output logic [4:0] dial250,
  output logic [4:0] dial440,
  output logic [4:0] dial630,
  output logic [4:0] dial1000,
  output logic [4:0] dial2500,
  output logic [4:0] dial5000,
  output logic [4:0] dial8000,
  output logic [4:0] dial14000,
  output logic [4:0] dial20000,
  output logic [3:0] sel_band,
  output logic       update,
  output logic [3:0] update_band
);

  localparam logic [4:0] DMAX      = 5'(DIAL_MAX);
  localparam logic [4:0] DCTR      = 5'(DIAL_CENTER);
  localparam logic [3:0] LAST_BAND = 4'(NBANDS - 1);
  localparam logic [3:0] ALL_BANDS = 4'hF;

  key_action_t action;

  logic [4:0] dial_q [NBANDS];
  logic [4:0] dial_d [NBANDS];
  logic [3:0] sel_q, sel_d;
  logic       update_q, update_d;
  logic [3:0] update_band_q, update_band_d;

  ps2_arrow_parser u_parser (
    .clk50        (clk50),
    .reset        (reset),
    .scan_code_i  (scan_code),
    .scan_valid_i (scan_valid),
    .action_o     (action)
  );

  always_comb begin
    dial_d        = dial_q;
    sel_d         = sel_q;
    update_d      = 1'b0;
    update_band_d = update_band_q;
    case (action)
      ACT_LEFT:  sel_d = (sel_q == 4'd0) ? LAST_BAND : sel_q - 4'd1;
      ACT_RIGHT: sel_d = (sel_q == LAST_BAND) ? 4'd0 : sel_q + 4'd1;
      // Saturation is checked before the step so the 5-bit value never wraps.
      ACT_UP: begin
        if (dial_q[sel_q] < DMAX) begin
          dial_d[sel_q] = dial_q[sel_q] + 5'd1;
          update_d      = 1'b1;
          update_band_d = sel_q;
        end
      end
      ACT_DOWN: begin
        if (dial_q[sel_q] != 5'd0) begin
          dial_d[sel_q] = dial_q[sel_q] - 5'd1;
          update_d      = 1'b1;
          update_band_d = sel_q;
        end
      end
      ACT_RECENTRE: begin
        for (int i = 0; i < NBANDS; i++) dial_d[i] = DCTR;
        update_d      = 1'b1;
        update_band_d = ALL_BANDS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBANDS; i++) dial_q[i] <= DCTR;
      sel_q         <= 4'd0;
      update_q      <= 1'b0;
      update_band_q <= 4'd0;
    end else begin
      dial_q        <= dial_d;
      sel_q         <= sel_d;
      update_q      <= update_d;
      update_band_q <= update_band_d;
    end
  end

  assign dial31      = dial_q[0];
  assign dial72      = dial_q[1];
  assign dial150     = dial_q[2];
  assign dial250     = dial_q[3];
  assign dial440     = dial_q[4];
  assign dial630     = dial_q[5];
  assign dial1000    = dial_q[6];
  assign dial2500    = dial_q[7];
  assign dial5000    = dial_q[8];
  assign dial8000    = dial_q[9];
  assign dial14000   = dial_q[10];
  assign dial20000   = dial_q[11];
  assign sel_band    = sel_q;
  assign update      = update_q;
  assign update_band = update_band_q;

endmodule

// File: tb/tb_eq_dial_controller.sv
// Scoreboard bench: a key-sequence reference model predicts the outputs for every accepted
// byte; a negedge monitor pops and compares whenever a byte was taken on the previous edge.
module tb_eq_dial_controller;

  typedef struct packed {
    logic [3:0]  sel;
    logic [59:0] dials;
    logic        upd;
    logic [3:0]  band;
  } exp_t;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [4:0] dial31, dial72, dial150, dial250, dial440, dial630;
  logic [4:0] dial1000, dial2500, dial5000, dial8000, dial14000, dial20000;
  logic [3:0] sel_band, update_band;
  logic       update;
  logic [59:0] dut_dials;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  logic acc = 1'b0;

  int         m_sel;
  int         m_dial [12];
  logic [7:0] pend [$];
  exp_t       sb [$];

  localparam logic [59:0] ALL_CENTRED = {12{5'd12}};

  eq_dial_controller #(.DIAL_MAX(24), .DIAL_CENTER(12)) dut (
    .clk50(clk50), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .dial31(dial31), .dial72(dial72), .dial150(dial150), .dial250(dial250),
    .dial440(dial440), .dial630(dial630), .dial1000(dial1000), .dial2500(dial2500),
    .dial5000(dial5000), .dial8000(dial8000), .dial14000(dial14000), .dial20000(dial20000),
    .sel_band(sel_band), .update(update), .update_band(update_band)
  );

  assign dut_dials = {dial20000, dial14000, dial8000, dial5000, dial2500, dial1000,
                      dial630, dial440, dial250, dial150, dial72, dial31};

  always #10 clk50 = ~clk50;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [59:0] m_pack();
    logic [59:0] r;
    for (int i = 0; i < 12; i++) r[i*5 +: 5] = 5'(m_dial[i]);
    return r;
  endfunction

  function automatic void m_reset();
    m_sel = 0;
    for (int i = 0; i < 12; i++) m_dial[i] = 12;
    pend.delete();
    sb.delete();
  endfunction

  // Model keeps the unfinished key sequence and interprets it once it is complete.
  function automatic void model_step(input logic [7:0] b);
    exp_t e;
    string act;
    act = "";
    pend.push_back(b);
    if (pend[0] == 8'hF0) begin
      if (pend.size() == 2) pend.delete();
    end else if (pend[0] == 8'hE0) begin
      if (pend.size() == 2) begin
        if (b == 8'hE0) void'(pend.pop_back());
        else if (b != 8'hF0) begin
          if (b == 8'h6B) act = "L";
          if (b == 8'h74) act = "R";
          if (b == 8'h75) act = "U";
          if (b == 8'h72) act = "D";
          pend.delete();
        end
      end else if (pend.size() == 3) pend.delete();
    end else begin
      if (b == 8'h2D) act = "C";
      pend.delete();
    end
    e.upd = 1'b0;
    e.band = 4'h0;
    case (act)
      "L": m_sel = (m_sel + 11) % 12;
      "R": m_sel = (m_sel + 1) % 12;
      "U": if (m_dial[m_sel] < 24) begin m_dial[m_sel]++; e.upd = 1'b1; e.band = 4'(m_sel); end
      "D": if (m_dial[m_sel] > 0)  begin m_dial[m_sel]--; e.upd = 1'b1; e.band = 4'(m_sel); end
      "C": begin
        for (int i = 0; i < 12; i++) m_dial[i] = 12;
        e.upd = 1'b1;
        e.band = 4'hF;
      end
      default: ;
    endcase
    e.sel = 4'(m_sel);
    e.dials = m_pack();
    sb.push_back(e);
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk50);
    scan_code = b;
    scan_valid = 1'b1;
    model_step(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk50);
      scan_valid = 1'b0;
    end
  endtask

  task automatic key(input logic [7:0] code, input int n);
    repeat (n) begin
      send(8'hE0);
      send(code);
    end
  endtask

  always @(posedge clk50 or posedge reset) begin
    if (reset) acc <= 1'b0;
    else       acc <= scan_valid;
  end

  always @(negedge clk50) begin
    if (!reset) begin
      if (update === 1'b1) pulses++;
      if (acc) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sel_band", sel_band, e.sel);
          chk("dials", dut_dials, e.dials);
          chk("update", update, e.upd);
          if (e.upd) chk("update_band", update_band, e.band);
        end
      end else begin
        chk("update_idle", update, 0);
      end
    end
  end

  initial begin
    m_reset();
    #25;
    chk("rst_async_sel", sel_band, 0);
    chk("rst_async_dials", dut_dials, ALL_CENTRED);
    @(negedge clk50);
    reset = 1'b0;
    #1;
    chk("rst_update", update, 0);
    chk("rst_update_band", update_band, 0);

    pulses = 0;
    key(8'h74, 3);
    idle(2);
    chk("right3_sel", sel_band, 3);
    chk("right3_pulses", pulses, 0);
    key(8'h6B, 3);

    pulses = 0;
    key(8'h75, 15);
    idle(2);
    chk("up15_dial31", dial31, 24);
    chk("up15_pulses", pulses, 12);

    key(8'h6B, 1);
    idle(1);
    chk("left_wrap_sel", sel_band, 11);
    pulses = 0;
    key(8'h72, 13);
    idle(2);
    chk("down13_dial20000", dial20000, 0);
    chk("down13_pulses", pulses, 12);

    pulses = 0;
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h2D);
    idle(2);
    chk("release_pulses", pulses, 0);
    key(8'h75, 1);
    idle(2);
    chk("after_release_up", dial20000, 1);

    send(8'h2D);
    idle(2);
    chk("recentre_dials", dut_dials, ALL_CENTRED);

    key(8'h75, 1);
    send(8'hE0);
    idle(2);
    @(negedge clk50);
    #2 reset = 1'b1;
    #1;
    chk("midrst_sel", sel_band, 0);
    chk("midrst_dial20000", dial20000, 12);
    chk("midrst_update", update, 0);
    @(negedge clk50);
    reset = 1'b0;
    m_reset();
    send(8'h75);
    idle(2);
    chk("postrst_dial31", dial31, 12);

    send(8'hE0); send(8'h74); send(8'hE0); send(8'h75);
    idle(2);
    chk("b2b_sel", sel_band, 1);
    chk("b2b_dial72", dial72, 13);

    for (int n = 0; n < 800; n++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2:       b = 8'hF0;
        3:       b = 8'h6B;
        4:       b = 8'h74;
        5, 6:    b = 8'h75;
        7:       b = 8'h72;
        8:       b = ($urandom_range(0, 7) == 0) ? 8'h2D : 8'h72;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eq_dial_controller.md
# eq_dial_controller

Keyboard-driven gain controller for the 12-band graphic equalizer. It consumes decoded PS/2 set-2 scan bytes and turns arrow-key presses into a selected-band index and twelve saturating 5-bit dial values (0..24, i.e. −12..+12 dB in 1 dB steps). Its dial outputs feed the equalizer bar display and the audio gain path directly. It also emits a one-cycle update strobe so downstream coefficient logic can reload only the changed band.

## Interface
Parameters:
- DIAL_MAX, 24: upper saturation value of every dial (+12 dB).
- DIAL_CENTER, 12: reset/recentre value (0 dB).

Ports:
- clk50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high.
- scan_code  input  8  PS/2 scan byte; qualified by scan_valid.
- scan_valid  input  1  one-cycle strobe per received byte.
- dial31, dial72, dial150, dial250, dial440, dial630, dial1000, dial2500, dial5000, dial8000, dial14000, dial20000  output  5 each  band gain, 0..DIAL_MAX. Band indices 0..11 map to these ports in this order.
- sel_band  output  4  currently selected band, 0..11.
- update  output  1  one-cycle pulse when any dial value changes.
- update_band  output  4  band changed this pulse; 4'hF means all bands were recentred.

## Operation
- **Reset values:**
  - every dial = DIAL_CENTER;
  - sel_band = 0;
  - update = 0;
  - update_band = 0;
  - parser in IDLE.
- **Parser FSM** advances only on cycles with scan_valid = 1.
  - IDLE:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK.
    - 0x2D ('R') -> RECENTRE action, stay in IDLE.
    - Any other byte is ignored; stay in IDLE.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0xE0 -> stay in EXT.
    - 0x6B -> LEFT, then IDLE.
    - 0x74 -> RIGHT, then IDLE.
    - 0x75 -> UP, then IDLE.
    - 0x72 -> DOWN, then IDLE.
    - Any other byte -> IDLE, no action.
  - BRK and EXT_BRK: the next byte is discarded -> IDLE. Key releases never act.
- **Typematic repeat:** repeated make codes act on every repeat, because each one is a fresh E0+code pair.
- **Actions:**
  - LEFT: sel_band − 1; 0 wraps to 11.
  - RIGHT: sel_band + 1; 11 wraps to 0.
  - UP: dial[sel_band] + 1, saturating at DIAL_MAX.
  - DOWN: dial[sel_band] − 1, saturating at 0.
  - RECENTRE: all dials = DIAL_CENTER.
- **Update strobe:**
  - UP or DOWN that actually changes the value: update = 1, update_band = sel_band.
  - UP/DOWN while saturated: no change, no pulse.
  - LEFT and RIGHT never pulse.
  - RECENTRE always pulses with update_band = 4'hF, even if all dials were already centred.
- **Arithmetic:**
  - Dial compare and increment are done in 5 bits. Compare against DIAL_MAX before incrementing; never rely on overflow.
  - sel_band is never outside 0..11, including after wrap.

## Timing
- Byte accepted on cycle N (scan_valid high) -> sel_band, the dial value and update are all registered and visible on cycle N+1.
- update is high for exactly one cycle.
- Latency is 1 cycle; no backpressure. One byte per cycle is sustainable.
- scan_valid on back-to-back cycles: each byte is processed in order. An action at N+1 uses the sel_band written at N+1, so RIGHT then UP on consecutive bytes adjusts the new band.
- Reset asserted mid-sequence (e.g. after 0xE0): parser returns to IDLE and all outputs take reset values immediately, asynchronously. The next byte is parsed fresh.
- scan_valid = 0: state, dials and sel_band hold; update = 0.

## Structure
- **Package eq_pkg** holds:
  - NBANDS = 12;
  - the scan-code constants (E0, F0, 6B, 74, 75, 72, 2D);
  - the parser state enum {IDLE, EXT, BRK, EXT_BRK};
  - the key-action enum {NONE, LEFT, RIGHT, UP, DOWN, RECENTRE}.
- **Sub-module ps2_arrow_parser:** contains the FSM only. It outputs a one-cycle action code, combinational from the current state and byte, so no extra latency is added.
- **Top level eq_dial_controller:** holds an internal 12×5 dial array, the sel_band register and the update logic, and fans the array out to the named ports.

## Test plan
- Reset, then E0 74 ×3 -> sel_band = 3, no update pulses, all dials = 12.
- E0 75 ×15 on band 0 -> dial31 reaches 24 after 12 presses. Exactly 12 update pulses with update_band = 0; the last 3 presses produce no pulse.
- E0 6B from sel_band = 0 -> sel_band = 11. Then E0 72 ×13 -> dial20000 = 0, 12 pulses.
- Release sequence E0 F0 75 -> no dial change, no pulse, parser back in IDLE. Likewise F0 2D -> no recentre.
- Dials set to mixed values, then byte 2D -> all dials = 12 next cycle, update = 1, update_band = 4'hF.
- Assert reset after E0, then send 75 -> not treated as UP; dial31 stays 12. Also cover back-to-back scan_valid E0,74,E0,75 -> sel_band = 1, dial72 = 13.
